labs_energy_sched: RTL and testbench

//  Scheduler/controller for the C_k correlation unit in the LABS search datapath.

---
 rtl/labs_energy_sched.sv | 169 ++++++++++++++++
 tb/tb_labs_energy_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/labs_energy_sched.sv
`default_nettype none
// ============================================================================
// Module      : labs_energy_sched
// Description : Sweeps shifts k=1..N-1 of a candidate LABS sequence through an
//               external C_k unit, squares and accumulates the aperiodic
//               correlations into an energy, presents (seq, E) on a
//               valid/ready port and tracks the minimum-energy sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module labs_energy_sched #(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEQ_WIDTH-1:0] in_seq,
  output logic [SEQ_WIDTH-1:0] ck_a,
  output logic [SEQ_WIDTH-1:0] ck_b,
  input  logic [7:0]           ck_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEQ_WIDTH-1:0] out_seq,
  output logic [E_WIDTH-1:0]   out_energy,
  input  logic                 clear_best,
  output logic                 best_valid,
  output logic [SEQ_WIDTH-1:0] best_seq,
  output logic [E_WIDTH-1:0]   best_energy,
  output logic [CNT_WIDTH-1:0] eval_count,
  output logic                 busy
);

  // Shift index only needs to reach N-1.
  localparam int                 c_k_w    = $clog2(SEQ_WIDTH);
  localparam logic [c_k_w-1:0]   c_k_last = c_k_w'(SEQ_WIDTH - 1);
  localparam logic [SEQ_WIDTH-1:0] c_ones = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SEQ_WIDTH-1:0]   r_seq;
  logic [c_k_w-1:0]       r_k;
  logic                   r_pending;
  logic [c_k_w-1:0]       r_pend_k;
  logic [E_WIDTH-1:0]     r_acc;
  logic                   r_out_valid;
  logic [SEQ_WIDTH-1:0]   r_out_seq;
  logic [E_WIDTH-1:0]     r_out_energy;
  logic                   r_best_valid;
  logic [SEQ_WIDTH-1:0]   r_best_seq;
  logic [E_WIDTH-1:0]     r_best_energy;
  logic [CNT_WIDTH-1:0]   r_eval_count;

  logic [7:0]             w_ck;
  logic [15:0]            w_ck16;
  logic [15:0]            w_sq;
  logic [E_WIDTH-1:0]     w_term;
  logic [E_WIDTH-1:0]     w_energy;

  // The k padded top positions of both operands are zero and always match, so
  // the raw score exceeds the aperiodic C_k by exactly the issued shift.
  assign w_ck     = ck_z - 8'(r_pend_k);
  assign w_ck16   = {{8{w_ck[7]}}, w_ck};
  // Low 16 bits of the two's-complement product are the exact square.
  assign w_sq     = w_ck16 * w_ck16;
  assign w_term   = E_WIDTH'(w_sq);
  assign w_energy = r_acc + w_term;

  // Operands come purely from registers so there is no input-to-output path.
  assign ck_a = r_seq >> r_k;
  assign ck_b = r_seq & (c_ones >> r_k);

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign out_seq     = r_out_seq;
  assign out_energy  = r_out_energy;
  assign best_valid  = r_best_valid;
  assign best_seq    = r_best_seq;
  assign best_energy = r_best_energy;
  assign eval_count  = r_eval_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)          w_next_state = S_RUN;
      S_RUN:   if (r_k == c_k_last)   w_next_state = S_DRAIN;
      S_DRAIN:                        w_next_state = S_DONE;
      S_DONE:  if (out_ready)         w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // Shift sequencing and energy accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq     <= '0;
      r_k       <= '0;
      r_pending <= 1'b0;
      r_pend_k  <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pending <= 1'b0;
          if (in_valid) begin
            r_seq <= in_seq;
            r_k   <= c_k_w'(1);
            r_acc <= '0;
          end
        end
        S_RUN: begin
          r_pending <= 1'b1;
          r_pend_k  <= r_k;
          if (r_pending)        r_acc <= w_energy;
          if (r_k != c_k_last)  r_k   <= r_k + c_k_w'(1);
        end
        default: r_pending <= 1'b0;
      endcase
    end
  end

  // Result port and completed-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_seq    <= '0;
      r_out_energy <= '0;
      r_eval_count <= '0;
    end else if (r_state == S_DRAIN) begin
      r_out_valid  <= 1'b1;
      r_out_seq    <= r_seq;
      r_out_energy <= w_energy;
      r_eval_count <= r_eval_count + CNT_WIDTH'(1);
    end else if (r_state == S_DONE && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Minimum-energy tracking; a clear takes priority over a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst || clear_best) begin
      r_best_valid  <= 1'b0;
      r_best_seq    <= '0;
      r_best_energy <= '1;
    end else if (r_state == S_DRAIN && w_energy < r_best_energy) begin
      r_best_valid  <= 1'b1;
      r_best_seq    <= r_seq;
      r_best_energy <= w_energy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_labs_energy_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_labs_energy_sched
// Description : Self-checking bench for labs_energy_sched with a behavioural
//               C_k unit and a direct autocorrelation energy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_labs_energy_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_seq = '0;
  logic [7:0]  ck_a, ck_b;
  logic [7:0]  ck_z;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_seq;
  logic [15:0] out_energy;
  logic        clear_best = 1'b0;
  logic        best_valid;
  logic [7:0]  best_seq;
  logic [15:0] best_energy;
  logic [31:0] eval_count;
  logic        busy;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [6:0]  b_in_seq = '0;
  logic [6:0]  b_ck_a, b_ck_b;
  logic [7:0]  b_ck_z;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [6:0]  b_out_seq;
  logic [15:0] b_out_energy;
  logic        b_best_valid;
  logic [6:0]  b_best_seq;
  logic [15:0] b_best_energy;
  logic [31:0] b_eval_count;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  int          m_best_e = 65535;
  logic [7:0]  m_best_s = '0;
  bit          m_best_v = 1'b0;
  int          m_count  = 0;

  always #5 clk = ~clk;

  labs_energy_sched #(.SEQ_WIDTH(8), .E_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_seq(in_seq),
    .ck_a(ck_a), .ck_b(ck_b), .ck_z(ck_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_seq(out_seq), .out_energy(out_energy), .clear_best(clear_best),
    .best_valid(best_valid), .best_seq(best_seq), .best_energy(best_energy),
    .eval_count(eval_count), .busy(busy)
  );

  labs_energy_sched #(.SEQ_WIDTH(7), .E_WIDTH(16), .CNT_WIDTH(32)) dut7 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_seq(b_in_seq),
    .ck_a(b_ck_a), .ck_b(b_ck_b), .ck_z(b_ck_z), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_seq(b_out_seq), .out_energy(b_out_energy),
    .clear_best(1'b0), .best_valid(b_best_valid), .best_seq(b_best_seq),
    .best_energy(b_best_energy), .eval_count(b_eval_count), .busy(b_busy)
  );

  // Behavioural C_k units: +1 per matching position, -1 per mismatch, registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_z   <= '0;
      b_ck_z <= '0;
    end else begin
      ck_z   <= 8'(8 - 2 * $countones(ck_a ^ ck_b));
      b_ck_z <= 8'(7 - 2 * $countones(b_ck_a ^ b_ck_b));
    end
  end

  // Energy straight from the definition of aperiodic autocorrelation.
  function automatic int ref_energy(input logic [127:0] s, input int n);
    int e;
    e = 0;
    for (int k = 1; k < n; k++) begin
      int c;
      c = 0;
      for (int i = 0; i < n - k; i++) c += (s[i] == s[i+k]) ? 1 : -1;
      e += c * c;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_record(input logic [7:0] s, input int e);
    m_count++;
    if (e < m_best_e) begin
      m_best_e = e;
      m_best_s = s;
      m_best_v = 1'b1;
    end
  endtask

  task automatic model_clear_best();
    m_best_e = 65535;
    m_best_s = '0;
    m_best_v = 1'b0;
  endtask

  task automatic check_best();
    chk("best_valid",  best_valid,  m_best_v);
    chk("best_energy", best_energy, m_best_e);
    chk("best_seq",    best_seq,    m_best_s);
    chk("eval_count",  eval_count,  m_count);
  endtask

  // Present a candidate; returns at the falling edge after the accepting edge.
  task automatic start_seq(input logic [7:0] s);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    in_seq   = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges from the accept until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 1'b0);
    chk("in_ready_back",  in_ready,  1'b1);
    chk("busy_idle",      busy,      1'b0);
  endtask

  task automatic do_seq(input logic [7:0] s, input int hold, input int exp_e);
    int lat;
    int e;
    e = ref_energy(128'(s), 8);
    start_seq(s);
    wait_done(lat);
    chk("latency", lat, 8);
    chk("out_energy", out_energy, e);
    chk("out_seq", out_seq, s);
    if (exp_e >= 0) chk("out_energy_known", out_energy, exp_e);
    model_record(s, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid",  out_valid,  1'b1);
      chk("hold_energy", out_energy, e);
      chk("hold_seq",    out_seq,    s);
      chk("hold_ready",  in_ready,   1'b0);
    end
    complete();
    check_best();
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst_out_valid",  out_valid,   1'b0);
    chk("rst_out_seq",    out_seq,     8'h00);
    chk("rst_out_energy", out_energy,  16'h0000);
    chk("rst_busy",       busy,        1'b0);
    chk("rst_in_ready",   in_ready,    1'b1);
    check_best();

    // All-zero sequence: every C_k = N-k.
    do_seq(8'h00, 0, 140);

    // Back-to-back run.
    do_seq(8'h00, 0, 140);
    do_seq(8'hC8, 0, 16);
    do_seq(8'hFF, 0, 140);
    chk("b2b_best_energy", best_energy, 16'd16);
    chk("b2b_best_seq",    best_seq,    8'hC8);
    chk("b2b_count",       eval_count,  32'd4);

    // Result held for five cycles of back-pressure.
    do_seq(8'h5A, 5, -1);

    // Reset while k_reg=4.
    start_seq(8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",      busy,       1'b0);
    chk("midrst_out_valid", out_valid,  1'b0);
    chk("midrst_in_ready",  in_ready,   1'b1);
    model_clear_best();
    m_count = 0;
    check_best();
    do_seq(8'h00, 0, 140);

    // clear_best coinciding with the best update.
    start_seq(8'hC8);
    repeat (7) @(negedge clk);
    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    m_count++;
    model_clear_best();
    chk("clr_out_valid",   out_valid,   1'b1);
    chk("clr_out_energy",  out_energy,  16'd16);
    chk("clr_best_valid",  best_valid,  1'b0);
    chk("clr_best_energy", best_energy, 16'hFFFF);
    complete();
    check_best();

    // Random candidates with random back-pressure.
    for (int r = 0; r < 20; r++) begin
      do_seq(8'($urandom), int'($urandom_range(0, 3)), -1);
    end

    // Barker-7 on the N=7 instance.
    @(negedge clk);
    b_in_seq   = 7'h58;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("b7_latency", lat, 7);
    chk("b7_energy",  b_out_energy, 16'd3);
    chk("b7_model",   b_out_energy, ref_energy(128'(7'h58), 7));
    chk("b7_best",    b_best_energy, 16'd3);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("b7_idle", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
